// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF    = 7'b0000000;
    localparam logic       DIGITS_OFF = 1'b0;

    // Bits needed to hold 0..max_count-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/hex2seg.sv
// Hex nibble to 7-segment pattern, bit6 = a ... bit0 = g, active-high.
module hex2seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: default first so every path assigns seg_o and no latch is inferred.
        seg_o = 7'b0000000;
        case (hex_i)
            4'h0: seg_o = 7'b1111110;
            4'h1: seg_o = 7'b0110000;
            4'h2: seg_o = 7'b1101101;
            4'h3: seg_o = 7'b1111001;
            4'h4: seg_o = 7'b0110011;
            4'h5: seg_o = 7'b1011011;
            4'h6: seg_o = 7'b1011111;
            4'h7: seg_o = 7'b1110000;
            4'h8: seg_o = 7'b1111111;
            4'h9: seg_o = 7'b1111011;
            4'hA: seg_o = 7'b1110111;
            4'hB: seg_o = 7'b0011111;
            4'hC: seg_o = 7'b1001110;
            4'hD: seg_o = 7'b0111101;
            4'hE: seg_o = 7'b1001111;
            4'hF: seg_o = 7'b1000111;
            default: seg_o = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-bus multi-digit 7-segment display,
// with double-buffered digit data committed only at frame boundaries.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DWELL_CYC  = 1000,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_data,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int unsigned CNT_MAX = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam int unsigned IDX_W   = cnt_width(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0]      GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d, next_idx;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [4*NUM_DIGITS-1:0] hex_act_q, hex_act_d, hex_sh_q, hex_sh_d;
    logic [NUM_DIGITS-1:0]   blank_act_q, blank_act_d, blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0]   dp_act_q, dp_act_d, dp_sh_q, dp_sh_d;
    logic                    pending_q, pending_d;

    logic [6:0]              seg_data_q, seg_data_d;
    logic                    seg_dp_q, seg_dp_d;
    logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
    logic                    frame_done_q, frame_done_d;

    logic                    frame_end, commit_now, show, lit;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    assign next_idx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // Boundary is the final clock of the last digit: its gap if gaps exist, else its dwell.
    assign frame_end = (idx_q == IDX_LAST) &&
                       ((GAP_CYC > 0) ? (state_q == ST_GAP  && cnt_q == GAP_LAST)
                                      : (state_q == ST_SHOW && cnt_q == DWELL_LAST));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                ST_SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (GAP_CYC > 0) state_d = ST_GAP;
                        else             idx_d   = next_idx;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        idx_d   = next_idx;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // With nothing on display there is no tearing to avoid, so loads commit at once.
    assign commit_now = frame_end || (state_q == ST_IDLE) || !enable;

    always_comb begin
        hex_sh_d    = hex_sh_q;
        blank_sh_d  = blank_sh_q;
        dp_sh_d     = dp_sh_q;
        hex_act_d   = hex_act_q;
        blank_act_d = blank_act_q;
        dp_act_d    = dp_act_q;
        pending_d   = pending_q;
        if (load) begin
            hex_sh_d   = hex_in;
            blank_sh_d = blank_in;
            dp_sh_d    = dp_in;
        end
        if (commit_now) begin
            pending_d = 1'b0;
            if (load) begin
                hex_act_d   = hex_in;
                blank_act_d = blank_in;
                dp_act_d    = dp_in;
            end else if (pending_q) begin
                hex_act_d   = hex_sh_q;
                blank_act_d = blank_sh_q;
                dp_act_d    = dp_sh_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are decoded from next-state values so select and segments share one edge.
    assign nibble = hex_act_d[{idx_d, 2'b00} +: 4];

    hex2seg u_hex2seg (
        .hex_i (nibble),
        .seg_o (dec_seg)
    );

    always_comb begin
        show         = (state_d == ST_SHOW);
        lit          = show && !blank_act_d[idx_d];
        digit_sel_d  = show ? (DIGIT0 << idx_d) : {NUM_DIGITS{DIGITS_OFF}};
        seg_data_d   = lit ? dec_seg : SEG_OFF;
        seg_dp_d     = lit && dp_act_d[idx_d];
        frame_done_d = frame_end;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            hex_act_q    <= '0;
            blank_act_q  <= '0;
            dp_act_q     <= '0;
            hex_sh_q     <= '0;
            blank_sh_q   <= '0;
            dp_sh_q      <= '0;
            pending_q    <= 1'b0;
            seg_data_q   <= SEG_OFF;
            seg_dp_q     <= 1'b0;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            hex_act_q    <= hex_act_d;
            blank_act_q  <= blank_act_d;
            dp_act_q     <= dp_act_d;
            hex_sh_q     <= hex_sh_d;
            blank_sh_q   <= blank_sh_d;
            dp_sh_q      <= dp_sh_d;
            pending_q    <= pending_d;
            seg_data_q   <= seg_data_d;
            seg_dp_q     <= seg_dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_data   = seg_data_q;
    assign seg_dp     = seg_dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: 4 digits, 4-clock dwell, 1-clock gap, 20-clock frame.
module tb_seg_scan_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned GP = 1;
    localparam int          SLOT = DW + GP;

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] hex_in;
    logic [3:0]  blank_in, dp_in;
    logic [6:0]  seg_data;
    logic        seg_dp;
    logic [3:0]  digit_sel;
    logic        frame_done, pending;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   end_req = 1'b0;
    int   f0;

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .DWELL_CYC  (DW),
        .GAP_CYC    (GP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .hex_in     (hex_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .seg_data   (seg_data),
        .seg_dp     (seg_dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    task automatic check(input string name, input int c, input logic [13:0] got, input logic [13:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got sel=%b seg=%b dp=%b fd=%b pend=%b, expected sel=%b seg=%b dp=%b fd=%b pend=%b",
                     name, c, got[13:10], got[9:3], got[2], got[1], got[0],
                     want[13:10], want[9:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic push(input int c, input logic [3:0] sel, input logic [6:0] seg,
                        input logic dp, input logic fd, input logic pend);
        exp_t e;
        e.cyc = c; e.sel = sel; e.seg = seg; e.dp = dp; e.fd = fd; e.pend = pend;
        exp_q.push_back(e);
    endtask

    task automatic push_dark(input int c);
        push(c, 4'b0000, 7'b0000000, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected frame: digit d lit for offsets 5d..5d+3, dark at 5d+4.
    task automatic push_frame(input int start, input logic [15:0] hex, input logic [3:0] blank,
                              input logic [3:0] dp, input logic fd_first, input int pend_rise,
                              input int len);
        for (int o = 0; o < len; o++) begin
            int         d;
            logic [3:0] sel;
            logic [6:0] seg;
            logic       p;
            d   = o / SLOT;
            sel = 4'b0000;
            seg = 7'b0000000;
            p   = 1'b0;
            if ((o % SLOT) < DW) begin
                sel = 4'b0001 << d;
                if (!blank[d]) begin
                    seg = seg_ref(hex[4*d +: 4]);
                    p   = dp[d];
                end
            end
            push(start + o, sel, seg, p, fd_first && (o == 0), (pend_rise >= 0) && (o >= pend_rise));
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_at(input int c, input logic [15:0] h, input logic [3:0] b, input logic [3:0] d);
        goto(c);
        load     = 1'b1;
        hex_in   = h;
        blank_in = b;
        dp_in    = d;
        goto(c + 1);
        load = 1'b0;
    endtask

    // Monitor: pops every expectation whose cycle has arrived and compares at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expect cyc=%0d expected at cyc=%0d", cyc, e.cyc);
            end else begin
                check("scan", cyc, {digit_sel, seg_data, seg_dp, frame_done, pending},
                      {e.sel, e.seg, e.dp, e.fd, e.pend});
            end
        end
        if (end_req) begin
            end_req = 1'b0;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL unchecked_expect got %0d left, expected 0", exp_q.size());
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d, expected finish before timeout", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        hex_in   = 16'h0000;
        blank_in = 4'b0000;
        dp_in    = 4'b0000;

        goto(2);
        push_dark(2);
        push_dark(3);
        push_dark(4);
        push_dark(5);
        rst_n = 1'b1;

        // Load while idle commits at once, then scan 4321.
        load_at(3, 16'h4321, 4'b0000, 4'b0000);
        goto(5);
        enable = 1'b1;
        f0 = cyc + 1;
        push_frame(f0,      16'h4321, 4'b0000, 4'b0000, 1'b0, -1, 20);
        push_frame(f0 + 20, 16'h4321, 4'b0000, 4'b0000, 1'b1,  8, 20);
        push_frame(f0 + 40, 16'hFFFF, 4'b0000, 4'b0000, 1'b1, -1, 20);
        push_frame(f0 + 60, 16'h5678, 4'b0000, 4'b0000, 1'b1,  3, 20);
        push_frame(f0 + 80, 16'hBBBB, 4'b0000, 4'b0000, 1'b1,  6, 20);

        // Mid-frame load waits for the boundary.
        load_at(f0 + 27, 16'hFFFF, 4'b0000, 4'b0000);
        // Load on the boundary clock goes straight to the active buffer.
        load_at(f0 + 59, 16'h5678, 4'b0000, 4'b0000);
        // Last load before the boundary wins.
        load_at(f0 + 62, 16'hAAAA, 4'b0000, 4'b0000);
        load_at(f0 + 70, 16'hBBBB, 4'b0000, 4'b0000);
        // Blank digit 2, decimal point on digit 0.
        load_at(f0 + 85, 16'h4321, 4'b0100, 4'b0001);
        push_frame(f0 + 100, 16'h4321, 4'b0100, 4'b0001, 1'b1, -1, 20);
        push_frame(f0 + 120, 16'h4321, 4'b0100, 4'b0001, 1'b1, -1, 12);

        // Drop enable while digit 2 is selected, then restart from digit 0.
        goto(f0 + 131);
        enable = 1'b0;
        push_dark(f0 + 132);
        push_dark(f0 + 133);
        push_dark(f0 + 134);
        goto(f0 + 134);
        enable = 1'b1;
        push_frame(f0 + 135, 16'h4321, 4'b0100, 4'b0001, 1'b0, -1, 20);
        push_frame(f0 + 155, 16'h4321, 4'b0100, 4'b0001, 1'b1,  3, 5);
        for (int c = 160; c < 165; c++) push_dark(f0 + c);
        push_frame(f0 + 165, 16'h0000, 4'b0000, 4'b0000, 1'b0, -1, 20);

        // Reset mid-frame with data pending: dark in the same cycle, pending data dropped.
        load_at(f0 + 157, 16'h9999, 4'b0000, 4'b0000);
        goto(f0 + 160);
        #1;
        rst_n  = 1'b0;
        enable = 1'b0;
        goto(f0 + 162);
        rst_n = 1'b1;
        goto(f0 + 164);
        enable = 1'b1;

        goto(f0 + 186);
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
